// File: rtl/flag_branch_unit.sv
// Post-ALU flag register and branch resolver for the single-cycle LEGv8 datapath.
// Holds NZCV, decides PC-select, and tracks a sticky control error and a taken-branch count.
module flag_branch_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_negative,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_carry_out,
    input  logic             set_flags,
    input  logic             alu_logic,
    input  logic             is_uncond,
    input  logic             is_cbz,
    input  logic             is_bcond,
    input  logic [3:0]       cond,
    input  logic             cnt_clear,
    output logic [3:0]       nzcv,
    output logic             take_branch,
    output logic             ctrl_error,
    output logic [CNT_W-1:0] taken_count
);

    logic flags_valid;
    logic multi_branch;
    logic bcond_no_flags;
    logic cond_true;

    function automatic logic cond_eval(input logic [3:0] f, input logic [3:0] c);
        logic n, z, cf, v;
        logic r;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (c)
            4'd0:    r = z;
            4'd1:    r = !z;
            4'd2:    r = cf;
            4'd3:    r = !cf;
            4'd4:    r = n;
            4'd5:    r = !n;
            4'd6:    r = v;
            4'd7:    r = !v;
            4'd8:    r = cf & !z;
            4'd9:    r = !cf | z;
            4'd10:   r = (n == v);
            4'd11:   r = (n != v);
            4'd12:   r = !z & (n == v);
            4'd13:   r = z | (n != v);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (&x) ? x : x + 1'b1;
    endfunction

    assign cond_true      = cond_eval(nzcv, cond);
    assign multi_branch   = (is_uncond & is_cbz) | (is_uncond & is_bcond) | (is_cbz & is_bcond);
    assign bcond_no_flags = is_bcond & !flags_valid;

    always_comb begin
        take_branch = 1'b0;
        if (reset) begin
            take_branch = 1'b0;
        end else if (is_uncond) begin
            take_branch = 1'b1;
        end else if (is_cbz) begin
            take_branch = alu_zero;
        end else if (is_bcond) begin
            // B.cond before any flag-setting instruction never branches, even AL/NV
            take_branch = flags_valid & cond_true;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nzcv        <= 4'b0000;
            flags_valid <= 1'b0;
            ctrl_error  <= 1'b0;
            taken_count <= '0;
        end else begin
            if (set_flags) begin
                // Logical ops define no carry/overflow, so C and V are cleared
                nzcv        <= {alu_negative, alu_zero,
                                alu_carry_out & !alu_logic, alu_overflow & !alu_logic};
                flags_valid <= 1'b1;
            end
            if (multi_branch || bcond_no_flags) begin
                ctrl_error <= 1'b1;
            end
            if (cnt_clear) begin
                taken_count <= '0;
            end else if (take_branch) begin
                taken_count <= sat_inc(taken_count);
            end
        end
    end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Scoreboard bench for flag_branch_unit (4-bit counter build): directed vectors push
// hand-computed expectations; a negedge monitor pops and compares them.
module tb_flag_branch_unit;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             alu_negative, alu_zero, alu_overflow, alu_carry_out;
    logic             set_flags, alu_logic;
    logic             is_uncond, is_cbz, is_bcond;
    logic [3:0]       cond;
    logic             cnt_clear;
    logic [3:0]       nzcv;
    logic             take_branch;
    logic             ctrl_error;
    logic [CNT_W-1:0] taken_count;

    typedef struct {
        string    name;
        int       sel;   // 0 take_branch, 1 nzcv, 2 ctrl_error, 3 taken_count
        int       val;
    } exp_t;

    exp_t q[$];
    int compared = 0;
    int mismatched = 0;

    flag_branch_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .alu_negative(alu_negative), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
        .set_flags(set_flags), .alu_logic(alu_logic),
        .is_uncond(is_uncond), .is_cbz(is_cbz), .is_bcond(is_bcond),
        .cond(cond), .cnt_clear(cnt_clear),
        .nzcv(nzcv), .take_branch(take_branch),
        .ctrl_error(ctrl_error), .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    // Monitor: expectations pushed after a posedge belong to that cycle.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            int act;
            e = q.pop_front();
            case (e.sel)
                0:       act = int'(take_branch);
                1:       act = int'(nzcv);
                2:       act = int'(ctrl_error);
                default: act = int'(taken_count);
            endcase
            compared++;
            if (act != e.val) begin
                mismatched++;
                $display("FAIL %s: got %0d expected %0d at %0t", e.name, act, e.val, $time);
            end
        end
    end

    task automatic idle_inputs();
        reset = 0; alu_negative = 0; alu_zero = 0; alu_overflow = 0; alu_carry_out = 0;
        set_flags = 0; alu_logic = 0; is_uncond = 0; is_cbz = 0; is_bcond = 0;
        cond = 4'd0; cnt_clear = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic expect_v(input string name, input int sel, input int val);
        exp_t e;
        e.name = name; e.sel = sel; e.val = val;
        q.push_back(e);
    endtask

    task automatic load_flags(input logic n, input logic z, input logic c, input logic v,
                              input logic lg);
        set_flags = 1; alu_logic = lg;
        alu_negative = n; alu_zero = z; alu_carry_out = c; alu_overflow = v;
    endtask

    task automatic bcond_chk(input string name, input logic [3:0] c, input int exp_take);
        next_cycle();
        is_bcond = 1; cond = c;
        expect_v(name, 0, exp_take);
    endtask

    initial begin
        idle_inputs();
        // reset with a competing B: take_branch must stay low
        next_cycle(); reset = 1; is_uncond = 1;
        expect_v("take_in_reset", 0, 0);
        next_cycle();
        expect_v("rst_nzcv", 1, 0); expect_v("rst_err", 2, 0); expect_v("rst_cnt", 3, 0);

        // B.cond AL before flags are valid
        bcond_chk("al_no_flags", 4'd14, 0);
        next_cycle();
        expect_v("err_no_flags", 2, 1); expect_v("nzcv_still0", 1, 0); expect_v("cnt_still0", 3, 0);

        next_cycle(); reset = 1;
        next_cycle(); load_flags(0, 1, 1, 0, 0);
        expect_v("err_cleared", 2, 0); expect_v("take_idle", 0, 0);
        bcond_chk("eq_z1", 4'd0, 1);
        expect_v("nzcv_0110", 1, 4'b0110);
        bcond_chk("hi_z1", 4'd8, 0);
        bcond_chk("hs_c1", 4'd2, 1);
        bcond_chk("lo_c1", 4'd3, 0);
        next_cycle();
        expect_v("cnt_2", 3, 2); expect_v("err_still0", 2, 0);

        // N=1, V=0
        next_cycle(); load_flags(1, 0, 0, 0, 0);
        bcond_chk("lt", 4'd11, 1);
        expect_v("nzcv_1000", 1, 4'b1000);
        bcond_chk("ge", 4'd10, 0);
        bcond_chk("gt", 4'd12, 0);
        bcond_chk("le", 4'd13, 1);
        bcond_chk("mi", 4'd4, 1);
        bcond_chk("pl", 4'd5, 0);
        bcond_chk("vc", 4'd7, 1);
        bcond_chk("nv", 4'd15, 1);
        next_cycle();
        expect_v("cnt_7", 3, 7);

        // flag write and B.cond in the same cycle: old Z=1 is used
        next_cycle(); load_flags(0, 1, 0, 0, 0);
        next_cycle(); load_flags(0, 0, 0, 0, 0); is_bcond = 1; cond = 4'd0;
        expect_v("eq_old_flags", 0, 1); expect_v("nzcv_0100", 1, 4'b0100);
        bcond_chk("eq_new_flags", 4'd0, 0);
        expect_v("nzcv_0000", 1, 4'b0000);

        // logical op clears C and V
        next_cycle(); load_flags(1, 0, 1, 1, 1);
        next_cycle(); is_cbz = 1; alu_zero = 0;
        expect_v("nzcv_logic", 1, 4'b1000); expect_v("cbz_nz", 0, 0);
        next_cycle(); is_cbz = 1; alu_zero = 1;
        expect_v("cbz_z", 0, 1);
        next_cycle();
        expect_v("cnt_9", 3, 9);

        // saturate the 4-bit counter
        for (int i = 0; i < 6; i++) begin
            next_cycle(); is_uncond = 1;
            expect_v("b_take", 0, 1);
        end
        next_cycle(); is_uncond = 1;
        expect_v("cnt_15", 3, 15);
        next_cycle();
        expect_v("cnt_sat", 3, 15);
        next_cycle(); cnt_clear = 1; is_uncond = 1;
        expect_v("take_w_clear", 0, 1);
        next_cycle();
        expect_v("cnt_cleared", 3, 0); expect_v("err_pre_multi", 2, 0);

        // two branch kinds at once
        next_cycle(); is_uncond = 1; is_cbz = 1; alu_zero = 0;
        expect_v("multi_take", 0, 1);
        next_cycle();
        expect_v("multi_err", 2, 1); expect_v("cnt_1", 3, 1);

        next_cycle();
        @(negedge clk);
        #1;
        if (taken_count !== 4'd1) begin
            mismatched++;
            $display("FAIL final_cnt: got %0d expected 1", taken_count);
        end
        if (ctrl_error !== 1'b1) begin
            mismatched++;
            $display("FAIL final_err: got %0b expected 1", ctrl_error);
        end
        if (nzcv !== 4'b1000) begin
            mismatched++;
            $display("FAIL final_nzcv: got %b expected 1000", nzcv);
        end
        if (mismatched != 0) begin
            $display("FAIL: %0d mismatches", mismatched);
        end else begin
            $display("PASS");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, compared %0d expected completion", compared);
        $fatal(1, "timeout");
    end

endmodule
